binary_to_bcd_serial: RTL and testbench
=======================================

// Module: binary_to_bcd_serial
// PURPOSE
//  Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD.
//  Sits between the square-root datapath (8-bit root) and the four-digit seven-segment display.
//  Replaces the combinational base converter.
//  Runs one bit per clock with a start/busy/done handshake, so the display only ever sees
//  complete, registered results.
// PARAMETERS
//  WIDTH_IN  8  width of the unsigned binary input
//  DIGITS    3  number of BCD output digits. Constraint: 10**DIGITS > 2**WIDTH_IN (checked at elaboration).
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              synchronous, active-high
//  start        in   1              request conversion of hexadecimal; sampled only in IDLE
//  hexadecimal  in   WIDTH_IN       unsigned binary value; captured on the accepted start edge
//  decimal      out  4*DIGITS       packed BCD result, digit 0 in [3:0]; registered
//  busy         out  1              high while a conversion is in flight
//  done         out  1              single-cycle pulse; decimal is valid and new in this cycle
// BEHAVIOUR
//  Interface: one clock, reset synchronous and active-high; ports named clock and reset.
//  Reset (any state, including mid-conversion):
//   - state = IDLE
//   - decimal = 0, busy = 0, done = 0
//   - scratch and bit counter cleared
//   - a conversion in flight is discarded; no done pulse is produced.
//  States:
//   - IDLE: busy = 0, done = 0.
//     - start = 1 at edge k: latch hexadecimal into shift register, clear BCD scratch,
//       counter = WIDTH_IN, go to SHIFT.
//   - SHIFT: busy = 1. Each edge, in order:
//     (a) every scratch digit >= 5 gets +3 (4-bit add, no carry between digits);
//     (b) {scratch, shift_reg} shifts left 1;
//     (c) counter decrements.
//     After the WIDTH_IN-th shift (counter reaches 0), go to DONE.
//   - DONE: one cycle.
//     - decimal <= scratch; done = 1; busy = 1.
//     - Next edge: go to IDLE.
//  Latency:
//   - start accepted at edge k -> done high and decimal updated in the cycle after edge k+WIDTH_IN+1
//     (default: 9 clocks after start).
//   - Next start is accepted at the first edge after done.
//   - Throughput: one conversion per WIDTH_IN+2 cycles.
//  Handshake:
//   - start while busy = 1 (SHIFT or DONE) is ignored, not queued.
//   - start held high continuously restarts a conversion each time IDLE is reached.
//   - The input is captured only on accept; later changes to hexadecimal do not affect the result.
//  decimal holds its last value between done pulses. It never shows partial scratch.
//  Arithmetic:
//   - Unsigned only. Each digit stays in 0..9 by construction.
//   - Maximum input 2**WIDTH_IN-1 (255 -> 2,5,5).
//  Simultaneous reset and start: reset wins.
// CONFIGURATION
//  BCD_LEADING_BLANK_EN
//   - Defined: on the DONE load, each leading zero digit above digit 0 is written as 4'hF
//     (blank code for the display driver). Scan runs from the top digit down and stops at the
//     first nonzero digit. Digit 0 is never blanked.
//     Example: 7 -> 12'hFF7; 0 -> 12'hFF0; 40 -> 12'hF40; 105 -> 12'h105.
//   - Undefined: decimal is plain BCD with zeros kept (7 -> 12'h007). No 4'hF code is ever produced.
//   - Latency and handshake are identical in both builds.
// TESTING
//  1. reset; hexadecimal = 8'd255, start pulse 1 cycle -> busy for 9 cycles; done on 9th cycle;
//     decimal = 12'h255.
//  2. hexadecimal = 0, start -> decimal = 12'h000 (12'hFF0 with BCD_LEADING_BLANK_EN); single done pulse.
//  3. hexadecimal = 100, start, then change hexadecimal to 200 and pulse start at cycle 3
//     -> second start ignored; decimal = 12'h100; one done only.
//  4. Start a conversion of 99; assert reset at cycle 4 -> next cycle busy = 0, decimal = 0;
//     no done pulse afterwards.
//  5. Back-to-back: start 9, then start 63 on the edge after done -> decimal = 12'h009
//     (12'hFF9 blanked), then 12'h063 (12'hF63 blanked); done spacing = 10 cycles.
//  6. Sweep all 256 inputs against a reference model (value%10, value/10%10, value/100).
//     Assert busy/done protocol and the decimal hold between done pulses.

Source files
------------

// File: rtl/binary_to_bcd_serial.sv
// Serial shift-and-add-3 (double-dabble) binary to packed BCD converter, one bit per clock.
// Optional build macro BCD_LEADING_BLANK_EN: blank leading zero digits as 4'hF on result load.
module binary_to_bcd_serial #(
    parameter int unsigned WIDTH_IN = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH_IN-1:0]   hexadecimal,
    output logic [4*DIGITS-1:0]   decimal,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + WIDTH_IN;
    localparam int unsigned CNT_W = $clog2(WIDTH_IN + 1);

    // Every input value must fit in the configured number of decimal digits.
    if ((64'(10) ** DIGITS) <= (64'(1) << WIDTH_IN)) begin : g_param_check
        $error("binary_to_bcd_serial: DIGITS too small for WIDTH_IN");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [WIDTH_IN-1:0] shift_reg;
    logic [WIDTH_IN-1:0] shift_n;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    scratch_n;
    logic [BCD_W-1:0]    adj;
    logic [CAT_W-1:0]    cat_sh;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_n;
    logic [BCD_W-1:0]    decimal_n;
    logic                busy_n;
    logic                done_n;

    // Per-digit +3 correction for digits >= 5; no carry between digits.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Final result formatting applied on the DONE load.
    function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] s);
`ifdef BCD_LEADING_BLANK_EN
        logic [BCD_W-1:0] r;
        logic             scanning;
        r        = s;
        scanning = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (scanning && (s[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                scanning = 1'b0;
            end
        end
        return r;
`else
        return s;
`endif
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        scratch_n = scratch;
        count_n   = count;
        decimal_n = decimal;
        done_n    = 1'b0;
        busy_n    = (state != S_IDLE);
        adj       = add3(scratch);
        cat_sh    = {adj, shift_reg} << 1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    shift_n   = hexadecimal;
                    scratch_n = '0;
                    count_n   = CNT_W'(WIDTH_IN);
                    state_n   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scratch_n, shift_n} = cat_sh;
                count_n              = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                decimal_n = format_result(scratch);
                done_n    = 1'b1;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; reset discards any conversion in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            decimal   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            shift_reg <= shift_n;
            scratch   <= scratch_n;
            count     <= count_n;
            decimal   <= decimal_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_serial.sv
// Directed and sweep bench for binary_to_bcd_serial; honours BCD_LEADING_BLANK_EN when defined.
module tb_binary_to_bcd_serial;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  hexadecimal;
    logic [11:0] decimal;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [11:0] EXP_0  = 12'hFF0;
    localparam logic [11:0] EXP_9  = 12'hFF9;
    localparam logic [11:0] EXP_63 = 12'hF63;
`else
    localparam logic [11:0] EXP_0  = 12'h000;
    localparam logic [11:0] EXP_9  = 12'h009;
    localparam logic [11:0] EXP_63 = 12'h063;
`endif

    binary_to_bcd_serial #(.WIDTH_IN(8), .DIGITS(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .hexadecimal (hexadecimal),
        .decimal     (decimal),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] expect_bcd(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'(v / 100);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
`ifdef BCD_LEADING_BLANK_EN
        if (d2 == 4'd0) begin
            d2 = 4'hF;
            if (d1 == 4'd0) d1 = 4'hF;
        end
`endif
        return {d2, d1, d0};
    endfunction

    // One conversion: ends on the done cycle (or after a bounded wait), optional mid-run start poke.
    task automatic run_conv(input string name, input logic [7:0] v, input logic [11:0] exp_dec,
                            input int poke_at, input logic [7:0] poke_val, input bit trail,
                            output int done_cyc);
        logic [11:0] prev;
        int busy_cnt, done_at;
        bit hold_ok, proto_ok;
        prev        = decimal;
        hexadecimal = v;
        start       = 1'b1;
        tick();
        start    = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        done_cyc = -1;
        hold_ok  = 1'b1;
        proto_ok = 1'b1;
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            tick();
            if (poke_at >= 0 && c == poke_at) begin
                hexadecimal = poke_val;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_at  = c;
                done_cyc = cyc;
                if (!busy) proto_ok = 1'b0;
            end else if (decimal !== prev) begin
                hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " decimal"}, 32'(decimal), 32'(exp_dec));
        check({name, " done_latency"}, 32'(done_at), 32'd9);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({name, " hold"}, 32'(hold_ok), 32'd1);
        check({name, " busy_with_done"}, 32'(proto_ok), 32'd1);
        if (trail) begin
            tick();
            check({name, " single_done"}, 32'(done), 32'd0);
            check({name, " idle_busy"}, 32'(busy), 32'd0);
            check({name, " decimal_held"}, 32'(decimal), 32'(exp_dec));
        end
    endtask

    initial begin
        int d_a, d_b, done_seen;
        reset       = 1'b1;
        start       = 1'b0;
        hexadecimal = 8'd0;
        tick();
        tick();
        check("reset decimal", 32'(decimal), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);

        // Simultaneous reset and start: reset wins, nothing starts.
        start       = 1'b1;
        hexadecimal = 8'd77;
        tick();
        reset = 1'b0;
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("reset_and_start no_activity", 32'(done_seen), 32'd0);

        run_conv("max255", 8'd255, 12'h255, -1, 8'd0, 1'b1, d_a);
        run_conv("zero", 8'd0, EXP_0, -1, 8'd0, 1'b1, d_a);
        run_conv("ignore_start", 8'd100, 12'h100, 3, 8'd200, 1'b1, d_a);

        // Reset mid-conversion discards it.
        hexadecimal = 8'd99;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset decimal", 32'(decimal), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("midreset no_done", 32'(done_seen), 32'd0);
        check("midreset decimal_after", 32'(decimal), 32'd0);

        // Back-to-back conversions.
        run_conv("b2b_9", 8'd9, EXP_9, -1, 8'd0, 1'b0, d_a);
        run_conv("b2b_63", 8'd63, EXP_63, -1, 8'd0, 1'b1, d_b);
        check("b2b spacing", 32'(d_b - d_a), 32'd10);

        // Full input sweep against the arithmetic reference.
        for (int v = 0; v < 256; v++) begin
            run_conv($sformatf("sweep_%0d", v), 8'(v), expect_bcd(v), -1, 8'd0, 1'b1, d_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
